// File: rtl/output_sram_ctrl.sv
// Arbiter and controller for the single-port output SRAM: accelerator writes,
// DMA reads, a hardware zero-fill sweep and a frame-completion counter.
module output_sram_ctrl #(
  parameter int DEPTH = 512,
  parameter int DW    = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_start,
  output logic          clear_busy,
  input  logic [AW:0]   frame_len,
  input  logic          acc_wvalid,
  output logic          acc_wready,
  input  logic [AW-1:0] acc_waddr,
  input  logic [DW-1:0] acc_wdata,
  input  logic          dma_rvalid,
  output logic          dma_rready,
  input  logic [AW-1:0] dma_raddr,
  output logic          dma_rdvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          frame_done,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_web,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [AW-1:0] clear_addr;
  logic          rr_ptr;      // 0: accelerator wins the next tie, 1: DMA wins
  logic [AW:0]   wcount;
  logic [AW:0]   wcount_inc;
  logic [AW:0]   eff_len;
  logic          both_valid;

  assign clear_busy = (state == CLEAR);
  assign dma_rdata  = sram_do;
  assign both_valid = acc_wvalid && dma_rvalid;
  assign wcount_inc = wcount + 1'b1;
  assign eff_len    = (frame_len == '0) ? (AW + 1)'(DEPTH) : frame_len;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    acc_wready = 1'b0;
    dma_rready = 1'b0;
    sram_cs    = 1'b0;
    sram_web   = 1'b1;
    sram_a     = '0;
    sram_di    = '0;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_next = CLEAR;
        end else if (acc_wvalid && (!dma_rvalid || !rr_ptr)) begin
          acc_wready = 1'b1;
          sram_cs    = 1'b1;
          sram_web   = 1'b0;
          sram_a     = acc_waddr;
          sram_di    = acc_wdata;
        end else if (dma_rvalid) begin
          dma_rready = 1'b1;
          sram_cs    = 1'b1;
          sram_a     = dma_raddr;
        end
      end
      CLEAR: begin
        sram_cs  = 1'b1;
        sram_web = 1'b0;
        sram_a   = clear_addr;
        if (clear_addr == AW'(DEPTH - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      clear_addr  <= '0;
      rr_ptr      <= 1'b0;
      wcount      <= '0;
      frame_done  <= 1'b0;
      dma_rdvalid <= 1'b0;
      sram_oe     <= 1'b0;
    end else begin
      state       <= state_next;
      frame_done  <= 1'b0;
      dma_rdvalid <= dma_rready;
      sram_oe     <= dma_rready;
      // Wraps back to 0 after the last word, ready for the next sweep.
      if (state == CLEAR) clear_addr <= clear_addr + 1'b1;
      if (both_valid && (acc_wready || dma_rready)) rr_ptr <= ~rr_ptr;
      if (state == IDLE && state_next == CLEAR) begin
        wcount <= '0;
      end else if (acc_wready) begin
        if (wcount_inc == eff_len) begin
          wcount     <= '0;
          frame_done <= 1'b1;
        end else begin
          wcount <= wcount_inc;
        end
      end
    end
  end

endmodule
